// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV64 control unit.
package mc_ctrl_pkg;

    typedef enum logic [4:0] {
        S_RESET, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_EXEC_SH, S_ADDR,
        S_MEM_RD, S_MEM_WR, S_WB_ALU, S_WB_LD, S_BRANCH, S_JAL, S_JALR, S_LUI,
        S_TRAP_SAVE, S_TRAP_VEC, S_TRAP_JUMP, S_HALT
    } state_t;

    typedef enum logic [2:0] {ALU_PASS, ALU_ADD, ALU_SUB, ALU_AND, ALU_SLT} alu_op_t;
    typedef enum logic [2:0] {WB_ALUOUT, WB_MDR, WB_IMM, WB_SLT, WB_SHIFT, WB_PC} wb_sel_t;
    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_t;
    typedef enum logic [1:0] {CAUSE_ILLEGAL, CAUSE_OVF, CAUSE_TIMEOUT} cause_t;

    typedef enum logic [3:0] {
        CLS_ILLEGAL, CLS_NOP, CLS_EBREAK, CLS_ALU_R, CLS_ALU_I, CLS_SHIFT,
        CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_LUI
    } instr_class_t;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

    localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef struct packed {
        instr_class_t cls;
        alu_op_t      aluOp;
        logic         ovfCheck;
        logic         isSlt;
        logic         immOperand;
        logic [1:0]   shiftSel;
        logic [2:0]   funct3;
    } decode_t;

    typedef struct packed {
        logic       pcWrite;
        logic       irLoad;
        logic       aLoad;
        logic       bLoad;
        logic       aluoutLoad;
        logic       mdrLoad;
        logic       rfWrite;
        logic       epcWrite;
        logic [1:0] pcSrc;
        logic       aluASel;
        logic [1:0] aluBSel;
        alu_op_t    aluOp;
        imm_sel_t   immSel;
        wb_sel_t    wbSel;
        logic [1:0] shiftSel;
        logic       memReq;
        logic       memWe;
        logic [1:0] memSize;
        logic       memUnsigned;
        logic [1:0] addrSel;
        logic       brEn;
        logic [2:0] brCond;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction classifier: the only logic that looks at opcode/funct3/funct7.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0] instr,
    output decode_t     dec
);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       shLeftOk;
    logic       shRightOk;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // RV64 immediate shifts carry a 6-bit shamt, leaving only instr[31:26] as funct6.
    always_comb begin
        if (XLEN == 64) begin
            shLeftOk  = (instr[31:26] == 6'b000000);
            shRightOk = shLeftOk || (instr[31:26] == 6'b010000);
        end else begin
            shLeftOk  = (funct7 == 7'b0000000);
            shRightOk = shLeftOk || (funct7 == 7'b0100000);
        end
    end

    always_comb begin
        dec        = '0;
        dec.cls    = CLS_ILLEGAL;
        dec.aluOp  = ALU_ADD;
        dec.funct3 = funct3;
        if (instr == EBREAK_INSTR) begin
            dec.cls = CLS_EBREAK;
        end else if (instr == NOP_INSTR) begin
            dec.cls = CLS_NOP;
        end else begin
            case (opcode)
                OPC_OP: begin
                    case (funct3)
                        3'd0: if (funct7 == 7'h00 || funct7 == 7'h20) begin
                            dec.cls      = CLS_ALU_R;
                            dec.ovfCheck = 1'b1;
                            dec.aluOp    = funct7[5] ? ALU_SUB : ALU_ADD;
                        end
                        3'd2: if (funct7 == 7'h00) begin
                            dec.cls   = CLS_ALU_R;
                            dec.aluOp = ALU_SLT;
                            dec.isSlt = 1'b1;
                        end
                        3'd7: if (funct7 == 7'h00) begin
                            dec.cls   = CLS_ALU_R;
                            dec.aluOp = ALU_AND;
                        end
                        3'd1: if (funct7 == 7'h00) dec.cls = CLS_SHIFT;
                        3'd5: if (funct7 == 7'h00 || funct7 == 7'h20) begin
                            dec.cls      = CLS_SHIFT;
                            dec.shiftSel = funct7[5] ? 2'd2 : 2'd1;
                        end
                        default: ;
                    endcase
                end
                OPC_OP_IMM: begin
                    dec.immOperand = 1'b1;
                    case (funct3)
                        3'd0: begin
                            dec.cls      = CLS_ALU_I;
                            dec.ovfCheck = 1'b1;
                        end
                        3'd2: begin
                            dec.cls   = CLS_ALU_I;
                            dec.aluOp = ALU_SLT;
                            dec.isSlt = 1'b1;
                        end
                        3'd7: begin
                            dec.cls   = CLS_ALU_I;
                            dec.aluOp = ALU_AND;
                        end
                        3'd1: if (shLeftOk) dec.cls = CLS_SHIFT;
                        3'd5: if (shRightOk) begin
                            dec.cls      = CLS_SHIFT;
                            dec.shiftSel = instr[30] ? 2'd2 : 2'd1;
                        end
                        default: ;
                    endcase
                end
                OPC_LOAD:   if (funct3 != 3'd7) dec.cls = CLS_LOAD;
                OPC_STORE:  if (!funct3[2]) dec.cls = CLS_STORE;
                OPC_BRANCH: if (funct3 != 3'd2 && funct3 != 3'd3) begin
                    dec.cls   = CLS_BRANCH;
                    dec.aluOp = ALU_SUB;
                end
                OPC_JAL:    dec.cls = CLS_JAL;
                OPC_JALR:   if (funct3 == 3'd0) dec.cls = CLS_JALR;
                OPC_LUI:    dec.cls = CLS_LUI;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV64 control FSM with registered Moore outputs.
// Define MC_CTRL_OVF_TRAP_EN to trap on signed overflow of add/addi/sub.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int MEM_TIMEOUT = 0,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        overflow,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_load,
    output logic        a_load,
    output logic        b_load,
    output logic        aluout_load,
    output logic        mdr_load,
    output logic        rf_write,
    output logic        epc_write,
    output logic [1:0]  pc_src,
    output logic        alu_a_sel,
    output logic [1:0]  alu_b_sel,
    output logic [2:0]  alu_op,
    output logic [2:0]  imm_sel,
    output logic [2:0]  wb_sel,
    output logic [1:0]  shift_sel,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_size,
    output logic        mem_unsigned,
    output logic [1:0]  addr_sel,
    output logic        br_en,
    output logic [2:0]  br_cond,
    output logic [1:0]  cause,
    output logic        halted,
    output state_t      dbgState
);
    decode_t          dec;
    state_t           state, nextState;
    ctrl_t            ctrlQ, ctrlNext;
    cause_t           causeQ, trapCause;
    logic             ovfQ, ovfNext;
    logic [CNT_W-1:0] waitCnt;
    logic             waiting, timeoutHit, readyGate;

    mc_ctrl_decode #(.XLEN(XLEN)) uDecode (.instr(instr), .dec(dec));

    // mem_req/mem_ready: a request holds address, size and we stable until
    // the cycle mem_ready is high; that cycle completes it.
    assign waiting    = state inside {S_FETCH, S_MEM_RD, S_MEM_WR, S_TRAP_VEC};
    assign timeoutHit = (MEM_TIMEOUT != 0) && waiting && !mem_ready
                        && (waitCnt == CNT_W'(MEM_TIMEOUT - 1));

`ifdef MC_CTRL_OVF_TRAP_EN
    assign ovfNext = (state == S_EXEC_R || state == S_EXEC_I) ? (overflow && dec.ovfCheck)
                   : (state == S_WB_ALU) ? 1'b0 : ovfQ;
`else
    logic unusedOverflow;
    assign unusedOverflow = overflow;
    assign ovfNext        = 1'b0;
`endif

    always_comb begin
        nextState = state;
        trapCause = causeQ;
        case (state)
            S_RESET:  nextState = S_FETCH;
            S_FETCH, S_MEM_RD, S_MEM_WR: begin
                if (mem_ready) begin
                    nextState = (state == S_FETCH) ? S_DECODE
                              : (state == S_MEM_RD) ? S_WB_LD : S_FETCH;
                end else if (timeoutHit) begin
                    nextState = S_TRAP_SAVE;
                    trapCause = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (dec.cls)
                    CLS_NOP:    nextState = S_FETCH;
                    CLS_EBREAK: nextState = S_HALT;
                    CLS_ALU_R:  nextState = S_EXEC_R;
                    CLS_ALU_I:  nextState = S_EXEC_I;
                    CLS_SHIFT:  nextState = S_EXEC_SH;
                    CLS_LOAD, CLS_STORE: nextState = S_ADDR;
                    CLS_BRANCH: nextState = S_BRANCH;
                    CLS_JAL:    nextState = S_JAL;
                    CLS_JALR:   nextState = S_JALR;
                    CLS_LUI:    nextState = S_LUI;
                    default: begin
                        nextState = S_TRAP_SAVE;
                        trapCause = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_EXEC_R, S_EXEC_I: nextState = S_WB_ALU;
            S_WB_ALU: begin
                nextState = ovfQ ? S_TRAP_SAVE : S_FETCH;
                if (ovfQ) trapCause = CAUSE_OVF;
            end
            S_ADDR:      nextState = (dec.cls == CLS_STORE) ? S_MEM_WR : S_MEM_RD;
            S_TRAP_SAVE: nextState = S_TRAP_VEC;
            S_TRAP_VEC: begin
                if (mem_ready)       nextState = S_TRAP_JUMP;
                else if (timeoutHit) nextState = S_HALT;
            end
            S_HALT:  nextState = S_HALT;
            default: nextState = S_FETCH;
        endcase
    end

    // Output bundle for the state being entered; registered alongside the state.
    always_comb begin
        ctrlNext = '0;
        case (nextState)
            S_FETCH: begin
                ctrlNext.memReq  = 1'b1;
                ctrlNext.memSize = 2'd2;
                ctrlNext.addrSel = 2'd1;
                ctrlNext.irLoad  = 1'b1;
                ctrlNext.pcWrite = 1'b1;
                ctrlNext.aluBSel = 2'd1;
                ctrlNext.aluOp   = ALU_ADD;
            end
            S_DECODE: begin
                ctrlNext.aLoad      = 1'b1;
                ctrlNext.bLoad      = 1'b1;
                ctrlNext.aluoutLoad = 1'b1;
                ctrlNext.aluBSel    = 2'd2;
                ctrlNext.immSel     = IMM_B;
                ctrlNext.aluOp      = ALU_ADD;
            end
            S_EXEC_R, S_EXEC_I: begin
                ctrlNext.aluoutLoad = 1'b1;
                ctrlNext.aluASel    = 1'b1;
                ctrlNext.aluBSel    = dec.immOperand ? 2'd2 : 2'd0;
                ctrlNext.aluOp      = dec.aluOp;
            end
            S_WB_ALU: begin
                ctrlNext.rfWrite = !ovfNext;
                ctrlNext.wbSel   = dec.isSlt ? WB_SLT : WB_ALUOUT;
            end
            S_EXEC_SH: begin
                ctrlNext.rfWrite  = 1'b1;
                ctrlNext.wbSel    = WB_SHIFT;
                ctrlNext.shiftSel = dec.shiftSel;
                ctrlNext.aluASel  = 1'b1;
                ctrlNext.aluBSel  = dec.immOperand ? 2'd2 : 2'd0;
            end
            S_ADDR: begin
                ctrlNext.aluoutLoad = 1'b1;
                ctrlNext.aluASel    = 1'b1;
                ctrlNext.aluBSel    = 2'd2;
                ctrlNext.aluOp      = ALU_ADD;
                ctrlNext.immSel     = (dec.cls == CLS_STORE) ? IMM_S : IMM_I;
            end
            S_MEM_RD, S_MEM_WR: begin
                ctrlNext.memReq      = 1'b1;
                ctrlNext.memWe       = (nextState == S_MEM_WR);
                ctrlNext.mdrLoad     = (nextState == S_MEM_RD);
                ctrlNext.memSize     = dec.funct3[1:0];
                ctrlNext.memUnsigned = dec.funct3[2];
            end
            S_WB_LD: begin
                ctrlNext.rfWrite     = 1'b1;
                ctrlNext.wbSel       = WB_MDR;
                ctrlNext.memSize     = dec.funct3[1:0];
                ctrlNext.memUnsigned = dec.funct3[2];
            end
            S_BRANCH: begin
                ctrlNext.aluASel = 1'b1;
                ctrlNext.aluOp   = ALU_SUB;
                ctrlNext.brEn    = 1'b1;
                ctrlNext.pcSrc   = 2'd1;
                ctrlNext.brCond  = dec.funct3;
            end
            S_JAL, S_JALR: begin
                ctrlNext.rfWrite = 1'b1;
                ctrlNext.wbSel   = WB_PC;
                ctrlNext.pcWrite = 1'b1;
                if (nextState == S_JAL) begin
                    ctrlNext.pcSrc = 2'd1;
                end else begin
                    ctrlNext.aluASel = 1'b1;
                    ctrlNext.aluBSel = 2'd2;
                    ctrlNext.aluOp   = ALU_ADD;
                end
            end
            S_LUI: begin
                ctrlNext.rfWrite = 1'b1;
                ctrlNext.wbSel   = WB_IMM;
                ctrlNext.immSel  = IMM_U;
            end
            S_TRAP_SAVE: begin
                ctrlNext.epcWrite = 1'b1;
                ctrlNext.aluBSel  = 2'd1;
                ctrlNext.aluOp    = ALU_SUB;
            end
            S_TRAP_VEC: begin
                ctrlNext.memReq  = 1'b1;
                ctrlNext.addrSel = 2'd2;
                ctrlNext.mdrLoad = 1'b1;
                ctrlNext.memSize = (XLEN == 64) ? 2'd3 : 2'd2;
            end
            S_TRAP_JUMP: begin
                ctrlNext.pcWrite = 1'b1;
                ctrlNext.pcSrc   = 2'd2;
            end
            S_HALT:  ctrlNext.halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_RESET;
            ctrlQ   <= '0;
            causeQ  <= CAUSE_ILLEGAL;
            ovfQ    <= 1'b0;
            waitCnt <= '0;
        end else begin
            state   <= nextState;
            ctrlQ   <= ctrlNext;
            ovfQ    <= ovfNext;
            waitCnt <= (waiting && nextState == state) ? waitCnt + CNT_W'(1) : '0;
            if (nextState == S_TRAP_SAVE) causeQ <= trapCause;
        end
    end

    // Load enables that belong to a memory request fire only on its ready cycle.
    assign readyGate    = !ctrlQ.memReq || mem_ready;
    assign pc_write     = ctrlQ.pcWrite && readyGate;
    assign ir_load      = ctrlQ.irLoad && readyGate;
    assign mdr_load     = ctrlQ.mdrLoad && readyGate;
    assign a_load       = ctrlQ.aLoad;
    assign b_load       = ctrlQ.bLoad;
    assign aluout_load  = ctrlQ.aluoutLoad;
    assign rf_write     = ctrlQ.rfWrite;
    assign epc_write    = ctrlQ.epcWrite;
    assign pc_src       = ctrlQ.pcSrc;
    assign alu_a_sel    = ctrlQ.aluASel;
    assign alu_b_sel    = ctrlQ.aluBSel;
    assign alu_op       = ctrlQ.aluOp;
    assign imm_sel      = ctrlQ.immSel;
    assign wb_sel       = ctrlQ.wbSel;
    assign shift_sel    = ctrlQ.shiftSel;
    assign mem_req      = ctrlQ.memReq;
    assign mem_we       = ctrlQ.memWe;
    assign mem_size     = ctrlQ.memSize;
    assign mem_unsigned = ctrlQ.memUnsigned;
    assign addr_sel     = ctrlQ.addrSel;
    assign br_en        = ctrlQ.brEn;
    assign br_cond      = ctrlQ.brCond;
    assign halted       = ctrlQ.halted;
    assign cause        = causeQ;
    assign dbgState     = state;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: vector table of instruction flows plus stall/trap/halt sequences.
module tb_mc_ctrl_fsm;
    import mc_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        overflow = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_write, ir_load, a_load, b_load, aluout_load, mdr_load, rf_write, epc_write;
    logic [1:0]  pc_src, alu_b_sel, shift_sel, mem_size, addr_sel, cause;
    logic        alu_a_sel, mem_req, mem_we, mem_unsigned, br_en, halted;
    logic [2:0]  alu_op, imm_sel, wb_sel, br_cond;
    state_t      dbgState;

    int errors = 0;
    int checks = 0;

    mc_ctrl_fsm #(.XLEN(64), .MEM_TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .instr(instr), .overflow(overflow), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_load(ir_load), .a_load(a_load), .b_load(b_load),
        .aluout_load(aluout_load), .mdr_load(mdr_load), .rf_write(rf_write),
        .epc_write(epc_write), .pc_src(pc_src), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .alu_op(alu_op), .imm_sel(imm_sel), .wb_sel(wb_sel), .shift_sel(shift_sel),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
        .addr_sel(addr_sel), .br_en(br_en), .br_cond(br_cond), .cause(cause),
        .halted(halted), .dbgState(dbgState)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] instr;
        int          nCyc;
        state_t      seq [5];
        logic [4:0]  rfMask;
        logic [4:0]  reqMask;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic addVec(input string n, input logic [31:0] ins, input int nc,
                          input state_t s0, input state_t s1, input state_t s2,
                          input state_t s3, input state_t s4,
                          input logic [4:0] rf, input logic [4:0] rq);
        vec_t v;
        v.name = n; v.instr = ins; v.nCyc = nc;
        v.seq[0] = s0; v.seq[1] = s1; v.seq[2] = s2; v.seq[3] = s3; v.seq[4] = s4;
        v.rfMask = rf; v.reqMask = rq;
        vecs.push_back(v);
    endtask

    task automatic doReset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        int reqCnt;
        addVec("add",  32'h002081B3, 4, S_FETCH, S_DECODE, S_EXEC_R, S_WB_ALU, S_FETCH, 5'b01000, 5'b00001);
        addVec("sub",  32'h402081B3, 4, S_FETCH, S_DECODE, S_EXEC_R, S_WB_ALU, S_FETCH, 5'b01000, 5'b00001);
        addVec("and",  32'h0020F1B3, 4, S_FETCH, S_DECODE, S_EXEC_R, S_WB_ALU, S_FETCH, 5'b01000, 5'b00001);
        addVec("slli", 32'h00309293, 3, S_FETCH, S_DECODE, S_EXEC_SH, S_FETCH, S_FETCH, 5'b00100, 5'b00001);
        addVec("srai", 32'h43F0D293, 3, S_FETCH, S_DECODE, S_EXEC_SH, S_FETCH, S_FETCH, 5'b00100, 5'b00001);
        addVec("lui",  32'h123450B7, 3, S_FETCH, S_DECODE, S_LUI, S_FETCH, S_FETCH, 5'b00100, 5'b00001);
        addVec("beq",  32'h00208463, 3, S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_FETCH, 5'b00000, 5'b00001);
        addVec("jal",  32'h010000EF, 3, S_FETCH, S_DECODE, S_JAL, S_FETCH, S_FETCH, 5'b00100, 5'b00001);
        addVec("jalr", 32'h000100E7, 3, S_FETCH, S_DECODE, S_JALR, S_FETCH, S_FETCH, 5'b00100, 5'b00001);
        addVec("sd",   32'h0020B423, 4, S_FETCH, S_DECODE, S_ADDR, S_MEM_WR, S_FETCH, 5'b00000, 5'b01001);
        addVec("ld",   32'h0000B183, 5, S_FETCH, S_DECODE, S_ADDR, S_MEM_RD, S_WB_LD, 5'b10000, 5'b01001);
        addVec("nop",  32'h00000013, 2, S_FETCH, S_DECODE, S_FETCH, S_FETCH, S_FETCH, 5'b00000, 5'b00001);

        // Reset state
        @(negedge clk);
        step();
        chk("reset state", 32'(dbgState), 32'(S_RESET));
        chk("reset outputs", {pc_write, ir_load, a_load, b_load, aluout_load, mdr_load, rf_write,
                              epc_write, mem_req, mem_we, br_en, halted, pc_src, addr_sel}, 32'h0);
        chk("reset cause", 32'(cause), 32'h0);
        reset = 1'b0;
        step();
        chk("first fetch", 32'(dbgState), 32'(S_FETCH));

        // Table-driven instruction flows, memory always ready
        mem_ready = 1'b1;
        foreach (vecs[k]) begin
            instr = vecs[k].instr;
            #1;
            for (int c = 0; c < vecs[k].nCyc; c++) begin
                chk($sformatf("%s state c%0d", vecs[k].name, c + 1), 32'(dbgState), 32'(vecs[k].seq[c]));
                chk($sformatf("%s rf_write c%0d", vecs[k].name, c + 1), 32'(rf_write), 32'(vecs[k].rfMask[c]));
                chk($sformatf("%s mem_req c%0d", vecs[k].name, c + 1), 32'(mem_req), 32'(vecs[k].reqMask[c]));
                step();
            end
            chk($sformatf("%s back to fetch", vecs[k].name), 32'(dbgState), 32'(S_FETCH));
        end

        // lw with three not-ready cycles in MEM_RD: 8 cycles total
        instr = 32'h0000A183;
        reqCnt = 0;
        for (int c = 1; c <= 8; c++) begin
            mem_ready = (c == 1 || c == 7);
            #1;
            reqCnt += int'(mem_req);
            if (c >= 4 && c <= 7) begin
                chk($sformatf("lw stall state c%0d", c), 32'(dbgState), 32'(S_MEM_RD));
                chk($sformatf("lw stall size c%0d", c), 32'(mem_size), 32'd2);
                chk($sformatf("lw stall addr_sel c%0d", c), 32'(addr_sel), 32'd0);
            end
            if (c >= 3) chk($sformatf("lw mdr_load c%0d", c), 32'(mdr_load), 32'(c == 7));
            if (c == 8) begin
                chk("lw wb rf_write", 32'(rf_write), 32'd1);
                chk("lw wb wb_sel", 32'(wb_sel), 32'd1);
            end
            step();
        end
        chk("lw mem_req cycles", 32'(reqCnt), 32'd5);
        chk("lw back to fetch", 32'(dbgState), 32'(S_FETCH));

        // addi overflow
        mem_ready = 1'b1;
        instr = 32'h00108093;
        overflow = 1'b1;
        step();
        step();
        chk("ovf exec_i", 32'(dbgState), 32'(S_EXEC_I));
        step();
        chk("ovf wb state", 32'(dbgState), 32'(S_WB_ALU));
`ifdef MC_CTRL_OVF_TRAP_EN
        chk("ovf rf_write suppressed", 32'(rf_write), 32'd0);
        step();
        overflow = 1'b0;
        chk("ovf trap_save", 32'(dbgState), 32'(S_TRAP_SAVE));
        chk("ovf epc_write", 32'(epc_write), 32'd1);
        chk("ovf cause", 32'(cause), 32'd1);
        step();
        chk("ovf vec state", 32'(dbgState), 32'(S_TRAP_VEC));
        chk("ovf vec addr_sel", 32'(addr_sel), 32'd2);
        chk("ovf vec mem_req", 32'(mem_req), 32'd1);
        chk("ovf vec mdr_load", 32'(mdr_load), 32'd1);
        step();
        chk("ovf jump pc_write", 32'(pc_write), 32'd1);
        chk("ovf jump pc_src", 32'(pc_src), 32'd2);
        step();
`else
        chk("ovf rf_write kept", 32'(rf_write), 32'd1);
        step();
        overflow = 1'b0;
`endif
        chk("ovf back to fetch", 32'(dbgState), 32'(S_FETCH));

        // Illegal opcode 0x7F: trap entry to handler fetch in 3 cycles
        instr = 32'h0000007F;
        step();
        step();
        chk("illegal trap_save", 32'(dbgState), 32'(S_TRAP_SAVE));
        chk("illegal cause", 32'(cause), 32'd0);
        step();
        chk("illegal trap_vec", 32'(dbgState), 32'(S_TRAP_VEC));
        step();
        chk("illegal trap_jump", 32'(dbgState), 32'(S_TRAP_JUMP));
        step();
        chk("illegal handler fetch", 32'(dbgState), 32'(S_FETCH));

        // ebreak halts until reset
        instr = EBREAK_INSTR;
        step();
        step();
        for (int c = 0; c < 100; c++) begin
            mem_ready = 1'($urandom_range(0, 1));
            instr = $urandom;
            #1;
            chk($sformatf("halt state c%0d", c), 32'(dbgState), 32'(S_HALT));
            chk($sformatf("halted c%0d", c), 32'(halted), 32'd1);
            step();
        end
        doReset();
        chk("after halt reset fetch", 32'(dbgState), 32'(S_FETCH));
        chk("after halt reset halted", 32'(halted), 32'd0);

        // Fetch timeout then vector timeout: cause 2, then double fault
        mem_ready = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("timeout fetch c%0d", c), 32'(dbgState), 32'(S_FETCH));
            chk($sformatf("timeout mem_req c%0d", c), 32'(mem_req), 32'd1);
            step();
        end
        chk("timeout trap_save", 32'(dbgState), 32'(S_TRAP_SAVE));
        chk("timeout cause", 32'(cause), 32'd2);
        chk("timeout req dropped", 32'(mem_req), 32'd0);
        step();
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("timeout vec c%0d", c), 32'(dbgState), 32'(S_TRAP_VEC));
            step();
        end
        chk("double fault halt", 32'(dbgState), 32'(S_HALT));
        chk("double fault halted", 32'(halted), 32'd1);

        // Asynchronous reset mid-request drops mem_req without a clock edge
        doReset();
        chk("pre-reset mem_req", 32'(mem_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async reset mem_req", 32'(mem_req), 32'd0);
        chk("async reset state", 32'(dbgState), 32'(S_RESET));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
